// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: definitions shared by the seven-segment display driver
// and the display read-back decoder. It holds the segment bit positions,
// the active-low hex glyphs and the decoder state encoding.
package seven_segment_pkg;

   // Cathode bit positions. Bit 0 is segment a and bit 7 is the decimal point.
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-low hex glyphs: a 0 bit lights the segment.
   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

   // Receive-side state. CAPTURE lasts one cycle after the inputs settle, and
   // HOLD waits for the next change so a steady pair is captured only once.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   // Nibble to active-low glyph. The display driver uses this for encoding.
   function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
      logic [6:0] g;
      case (nibble)
         4'h0:    g = GLYPH_0;
         4'h1:    g = GLYPH_1;
         4'h2:    g = GLYPH_2;
         4'h3:    g = GLYPH_3;
         4'h4:    g = GLYPH_4;
         4'h5:    g = GLYPH_5;
         4'h6:    g = GLYPH_6;
         4'h7:    g = GLYPH_7;
         4'h8:    g = GLYPH_8;
         4'h9:    g = GLYPH_9;
         4'hA:    g = GLYPH_A;
         4'hB:    g = GLYPH_B;
         4'hC:    g = GLYPH_C;
         4'hD:    g = GLYPH_D;
         4'hE:    g = GLYPH_E;
         default: g = GLYPH_F;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: combinational reverse lookup from an active-low 7-segment
// pattern to a hex nibble. If the pattern is not one of the 16 hex glyphs,
// including the blank pattern, valid is 0 and the nibble is 0.
module seg_glyph_decode
   import seven_segment_pkg::*;
(
   input  logic [6:0] segments,
   output logic [3:0] nibble,
   output logic       valid
);

   // Exact match against the glyph table. Patterns outside it fall to the default.
   always_comb begin
      nibble = 4'h0;
      valid  = 1'b1;
      case (segments)
         GLYPH_0: nibble = 4'h0;
         GLYPH_1: nibble = 4'h1;
         GLYPH_2: nibble = 4'h2;
         GLYPH_3: nibble = 4'h3;
         GLYPH_4: nibble = 4'h4;
         GLYPH_5: nibble = 4'h5;
         GLYPH_6: nibble = 4'h6;
         GLYPH_7: nibble = 4'h7;
         GLYPH_8: nibble = 4'h8;
         GLYPH_9: nibble = 4'h9;
         GLYPH_A: nibble = 4'hA;
         GLYPH_B: nibble = 4'hB;
         GLYPH_C: nibble = 4'hC;
         GLYPH_D: nibble = 4'hD;
         GLYPH_E: nibble = 4'hE;
         GLYPH_F: nibble = 4'hF;
         default: begin
            nibble = 4'h0;
            valid  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: watches the multiplexed anode/cathode drive of a
// seven-segment display and rebuilds the displayed hex digits and decimal
// points. It publishes each full frame in one update with a one-cycle strobe.
// Optional feature: define SEG_DEC_TIMEOUT_EN to add a refresh watchdog that
// drives 'stale'. Without the macro, 'stale' is tied low.
module seven_segment_decoder
   import seven_segment_pkg::*;
#(
   parameter int NUM_SEGMENTS  = 8,
   parameter int CLK_PER       = 10,
   parameter int REFR_RATE     = 1000,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SEGMENTS-1:0]   anode,
   input  logic [7:0]                cathode,
   output logic [NUM_SEGMENTS*4-1:0] encoded,
   output logic [NUM_SEGMENTS-1:0]   digit_point,
   output logic                      frame_valid,
   output logic                      glyph_error,
   output logic                      anode_error,
   output logic                      stale
);

   localparam int         IDX_W       = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
   localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   logic [NUM_SEGMENTS-1:0]   anode_q;
   logic [NUM_SEGMENTS-1:0]   anode_p;
   logic [7:0]                cathode_q;
   logic [7:0]                cathode_p;
   logic                      changed;
   logic [7:0]                stable_cnt;
   logic [7:0]                stable_next;
   logic                      capture_now;
   logic                      blank;
   logic                      single;
   logic                      accept;
   logic [IDX_W-1:0]          digit_idx;
   logic [3:0]                nibble;
   logic                      glyph_ok;
   logic                      timeout_hit;
   state_t                    state;
   logic [NUM_SEGMENTS*4-1:0] shadow;
   logic [NUM_SEGMENTS*4-1:0] shadow_next;
   logic [NUM_SEGMENTS-1:0]   shadow_dp;
   logic [NUM_SEGMENTS-1:0]   shadow_dp_next;
   logic [NUM_SEGMENTS-1:0]   mask;
   logic [NUM_SEGMENTS-1:0]   mask_next;

   // Register the pins once, plus one older copy so that input changes can be seen.
   // The reset value is the blank display, so an idle bus gives no change event.
   always_ff @(posedge clk) begin
      if (reset) begin
         anode_q   <= '1;
         anode_p   <= '1;
         cathode_q <= '1;
         cathode_p <= '1;
      end else begin
         anode_q   <= anode;
         anode_p   <= anode_q;
         cathode_q <= cathode;
         cathode_p <= cathode_q;
      end
   end

   assign changed = (anode_q != anode_p) || (cathode_q != cathode_p);

   // Next stability count: restart on any change, otherwise count up to the settle limit.
   always_comb begin
      stable_next = stable_cnt;
      if (changed) begin
         stable_next = 8'd0;
      end else if (stable_cnt != SETTLE_MAX) begin
         stable_next = stable_cnt + 8'd1;
      end
   end

   // Stability counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_cnt <= 8'd0;
      end else begin
         stable_cnt <= stable_next;
      end
   end

   // Capture fires on the edge where the pair completes its settle window.
   // The 'changed' term lets SETTLE_CYCLES = 1 capture directly from IDLE/HOLD.
   assign capture_now = (stable_next == SETTLE_LAST) && ((state == SETTLE) || changed);

   assign blank  = &anode_q;
   assign single = $onehot(~anode_q);
   assign accept = capture_now && single;

   // Position of the low anode bit. The result is used only when exactly one bit is low.
   always_comb begin
      digit_idx = '0;
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
         if (!anode_q[i]) begin
            digit_idx = IDX_W'(i);
         end
      end
   end

   seg_glyph_decode u_glyph (
      .segments (cathode_q[SEG_G:SEG_A]),
      .nibble   (nibble),
      .valid    (glyph_ok)
   );

   // Shadow frame and mask after this cycle's capture. The last digit of a
   // frame is merged here so that the published frame already contains it.
   always_comb begin
      shadow_next    = shadow;
      shadow_dp_next = shadow_dp;
      mask_next      = mask;
      if (accept) begin
         shadow_next[digit_idx*4 +: 4] = nibble;
         shadow_dp_next[digit_idx]     = cathode_q[SEG_DP];
         mask_next[digit_idx]          = 1'b1;
      end
   end

`ifdef SEG_DEC_TIMEOUT_EN
   localparam longint TIMEOUT = 2000000000 / (longint'(CLK_PER) * longint'(REFR_RATE));
   localparam int     WD_W    = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            stale_r;

   assign timeout_hit = !accept && (wd_cnt == WD_W'(TIMEOUT - 1));

   // Refresh watchdog: each accepted digit restarts it. When no digit arrives
   // for TIMEOUT cycles, stale is set and stays set until the next accepted digit.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt  <= '0;
         stale_r <= 1'b0;
      end else if (accept) begin
         wd_cnt  <= '0;
         stale_r <= 1'b0;
      end else begin
         if (wd_cnt != WD_W'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (timeout_hit) begin
            stale_r <= 1'b1;
         end
      end
   end

   assign stale = stale_r;
`else
   assign timeout_hit = 1'b0;
   assign stale       = 1'b0;
`endif

   // Main FSM with registered frame outputs and one-cycle error/frame strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         shadow      <= '0;
         shadow_dp   <= '1;
         mask        <= '0;
         encoded     <= '0;
         digit_point <= '1;
         frame_valid <= 1'b0;
         glyph_error <= 1'b0;
         anode_error <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         glyph_error <= 1'b0;
         anode_error <= 1'b0;

         if (capture_now) begin
            state <= CAPTURE;
         end else begin
            case (state)
               IDLE:    if (changed) state <= SETTLE;
               SETTLE:  state <= SETTLE;
               CAPTURE: state <= changed ? SETTLE : HOLD;
               HOLD:    if (changed) state <= SETTLE;
               default: state <= IDLE;
            endcase
         end

         if (accept) begin
            shadow      <= shadow_next;
            shadow_dp   <= shadow_dp_next;
            glyph_error <= !glyph_ok;
            if (&mask_next) begin
               encoded     <= shadow_next;
               digit_point <= shadow_dp_next;
               frame_valid <= 1'b1;
               mask        <= '0;
            end else begin
               mask <= mask_next;
            end
         end else if (capture_now && !blank) begin
            anode_error <= 1'b1;
         end else if (timeout_hit) begin
            mask <= '0;
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb_seven_segment_decoder: directed scoreboard bench for seven_segment_decoder.
// The stimulus process pushes the expected frames and error pulses into queues.
// A monitor pops an entry each time the DUT strobes an output and compares it.
module tb_seven_segment_decoder;

   localparam int N = 8;
`ifdef SEG_DEC_TIMEOUT_EN
   localparam int TB_REFR  = 1000000;
   localparam bit STALE_ON = 1'b1;
`else
   localparam int TB_REFR  = 1000;
   localparam bit STALE_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  anode;
   logic [7:0]    cathode;
   logic [N*4-1:0] encoded;
   logic [N-1:0]  digit_point;
   logic          frame_valid;
   logic          glyph_error;
   logic          anode_error;
   logic          stale;

   typedef struct {
      logic [31:0] enc;
      logic [7:0]  dp;
   } frame_t;

   frame_t frame_q[$];
   int     exp_glyph[$];
   int     exp_anode[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     frame_cyc = -1;
   int     start_cyc;

   // Segments lit for each hex digit, with bit 0 = a. These are worked out by hand from the glyph list.
   logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seven_segment_decoder #(
      .NUM_SEGMENTS  (N),
      .CLK_PER       (10),
      .REFR_RATE     (TB_REFR),
      .SETTLE_CYCLES (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .anode       (anode),
      .cathode     (cathode),
      .encoded     (encoded),
      .digit_point (digit_point),
      .frame_valid (frame_valid),
      .glyph_error (glyph_error),
      .anode_error (anode_error),
      .stale       (stale)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pat(input int v, input bit dp_lit);
      logic [6:0] l;
      l = lit[v];
      return {~dp_lit, ~l};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] c, input int n);
      anode   = a;
      cathode = c;
      repeat (n) @(negedge clk);
   endtask

   task automatic showDigit(input int idx, input int val, input bit dp_lit, input int n);
      logic [7:0] one;
      one = 8'd1 << idx;
      applyStimulus(~one, pat(val, dp_lit), n);
   endtask

   // Monitor: on each strobe, pop the matching expectation and compare it.
   always @(negedge clk) begin
      if (!reset) begin
         if (frame_valid) begin
            if (frame_q.size() == 0) begin
               checkOutput("unexpected frame_valid", 1, 0);
            end else begin
               frame_t f;
               f = frame_q.pop_front();
               frame_cyc = cyc;
               checkOutput("frame encoded", encoded, f.enc);
               checkOutput("frame digit_point", digit_point, f.dp);
            end
         end
         if (glyph_error) begin
            if (exp_glyph.size() == 0) checkOutput("unexpected glyph_error", 1, 0);
            else begin
               void'(exp_glyph.pop_front());
               checkOutput("glyph_error pulse", glyph_error, 1);
            end
         end
         if (anode_error) begin
            if (exp_anode.size() == 0) checkOutput("unexpected anode_error", 1, 0);
            else begin
               void'(exp_anode.pop_front());
               checkOutput("anode_error pulse", anode_error, 1);
            end
         end
      end
   end

   initial begin
      reset   = 1'b1;
      anode   = '1;
      cathode = '1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("reset encoded", encoded, 32'h0);
      checkOutput("reset digit_point", digit_point, 8'hFF);
      checkOutput("reset frame_valid", frame_valid, 0);
      checkOutput("reset stale", stale, 0);

      // Frame 1: digits 0..7 show 1..8, with the DP of digit 3 lit.
      frame_q.push_back('{32'h87654321, 8'hF7});
      for (int i = 0; i < 7; i++) showDigit(i, i + 1, (i == 3), 20);
      start_cyc = cyc;
      showDigit(7, 8, 1'b0, 20);
      checkOutput("frame1 latency", frame_cyc - start_cyc, 5);
      checkOutput("frame1 held encoded", encoded, 32'h87654321);

      // Frame 2: A b C d E F 0 1. Blank glitches of 2 and 3 samples must be ignored.
      frame_q.push_back('{32'h10FEDCBA, 8'hFF});
      showDigit(0, 10, 1'b0, 12);
      showDigit(1, 11, 1'b0, 12);
      showDigit(2, 12, 1'b0, 8);
      applyStimulus(8'hFB, 8'hFF, 2);
      showDigit(2, 12, 1'b0, 10);
      showDigit(3, 13, 1'b0, 8);
      applyStimulus(8'hF7, 8'hFF, 3);
      showDigit(3, 13, 1'b0, 10);
      for (int i = 4; i < 8; i++) showDigit(i, (i + 10) % 16, 1'b0, 12);
      checkOutput("frame2 encoded", encoded, 32'h10FEDCBA);

      // Frame 3: an anode error mid-frame must not touch the mask. Digit 0 is blank and gives a glyph error.
      exp_anode.push_back(1);
      exp_glyph.push_back(1);
      frame_q.push_back('{32'h57986420, 8'h7F});
      showDigit(2, 4, 1'b0, 12);
      showDigit(3, 6, 1'b0, 12);
      showDigit(4, 8, 1'b0, 12);
      showDigit(5, 9, 1'b0, 12);
      showDigit(6, 7, 1'b0, 12);
      showDigit(7, 5, 1'b1, 12);
      applyStimulus(8'hFC, pat(3, 1'b0), 10);
      checkOutput("no frame after anode error", frame_q.size(), 1);
      showDigit(1, 2, 1'b0, 12);
      applyStimulus(8'hFE, 8'hFF, 12);
      checkOutput("frame3 encoded", encoded, 32'h57986420);

      // Reset after 5 digits. The next scan runs in reverse order, so a mask left over from before the reset would complete a frame early.
      for (int i = 0; i < 5; i++) showDigit(i, 7, 1'b1, 12);
      reset   = 1'b1;
      anode   = '1;
      cathode = '1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("mid-frame reset encoded", encoded, 32'h0);
      checkOutput("mid-frame reset digit_point", digit_point, 8'hFF);
      frame_q.push_back('{32'hFEDCBA98, 8'hFE});
      for (int i = 7; i >= 0; i--) showDigit(i, i + 8, (i == 0), 12);
      checkOutput("frame4 encoded", encoded, 32'hFEDCBA98);

      // Frozen display: stale follows the build option. The next accepted digit clears it.
      showDigit(3, 5, 1'b0, 260);
      checkOutput("stale after freeze", stale, STALE_ON);
      showDigit(4, 6, 1'b0, 8);
      checkOutput("stale after new digit", stale, 0);

      repeat (5) @(negedge clk);
      checkOutput("frames outstanding", frame_q.size(), 0);
      checkOutput("glyph errors outstanding", exp_glyph.size(), 0);
      checkOutput("anode errors outstanding", exp_anode.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
